// File: rtl/lc3_int_ctrl_pkg.sv
// Shared types and constants for the LC-3 interrupt controller.
package lc3Pkg;
    localparam logic [7:0] INT_VEC_BASE = 8'h80;
    localparam int         INT_PRIO_W   = 3;

    typedef enum logic [1:0] {INT_IDLE, INT_REQ, INT_HOLD} IntCtrlStates;
endpackage

// File: rtl/lc3_int_ctrl_if.sv
// INT / int_ack handshake between the interrupt controller (master) and control unit (slave).
interface lc3_int_ctrl_if #(
    parameter int PRIO_W = 3,
    parameter int VEC_W  = 8
);
    logic              INT;
    logic [VEC_W-1:0]  int_vector;
    logic [PRIO_W-1:0] int_prio;
    logic              int_ack;

    modport master (output INT, int_vector, int_prio, input int_ack);
    modport slave  (input INT, int_vector, int_prio, output int_ack);
endinterface

// File: rtl/lc3_int_arbiter.sv
// Combinational priority pick: highest priority wins, ties go to the lowest index.
module lc3_int_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int PRIO_W  = 3,
    localparam int IDX_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic [NUM_SRC-1:0]             eligible,
    input  logic [NUM_SRC-1:0][PRIO_W-1:0] prio,
    output logic [IDX_W-1:0]               winIdx,
    output logic                           winValid
);
    logic [PRIO_W-1:0] bestPrio;

    always_comb begin
        winIdx   = '0;
        winValid = 1'b0;
        bestPrio = '0;
        // Strict compare keeps the earlier (lower) index on a tie.
        for (int i = 0; i < NUM_SRC; i++) begin
            if (eligible[i] && (!winValid || prio[i] > bestPrio)) begin
                winValid = 1'b1;
                bestPrio = prio[i];
                winIdx   = IDX_W'(i);
            end
        end
    end
endmodule

// File: rtl/lc3_int_ctrl.sv
// Interrupt controller feeding the LC-3 control unit INT input: latches requests,
// arbitrates against PSR priority and holds a stable vector/priority until acked.
module lc3_int_ctrl
    import lc3Pkg::*;
#(
    parameter int                 NUM_SRC   = 4,
    parameter int                 PRIO_W    = INT_PRIO_W,
    parameter int                 VEC_W     = 8,
    parameter logic [VEC_W-1:0]   VEC_BASE  = VEC_W'(INT_VEC_BASE),
    parameter logic [NUM_SRC-1:0] EDGE_MASK = {NUM_SRC{1'b1}},
    localparam int                SEL_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_SRC-1:0]   irq,
    input  logic [PRIO_W-1:0]    cur_prio,
    input  logic                 cfg_we,
    input  logic [SEL_W-1:0]     cfg_sel,
    input  logic [PRIO_W:0]      cfg_data,
    lc3_int_ctrl_if.master       bus,
    output logic [NUM_SRC-1:0]   pending
);
    if (int'(VEC_BASE) + NUM_SRC - 1 >= (1 << VEC_W)) begin : gVecRange
        $error("lc3_int_ctrl: VEC_BASE+NUM_SRC-1 does not fit in VEC_W bits");
    end

    IntCtrlStates                 state;
    logic [NUM_SRC-1:0]           en, irqPrev, eligible, ackClr;
    logic [NUM_SRC-1:0][PRIO_W-1:0] prio;
    logic [SEL_W-1:0]             capIdx, winIdx;
    logic                         winValid, capElig;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_SRC; i++)
            eligible[i] = pending[i] & en[i] & (prio[i] > cur_prio);
    end

    assign capElig = eligible[capIdx];

    // Only an edge source taken while requesting loses its pending bit on ack.
    always_comb begin
        ackClr = '0;
        if (state == INT_REQ && bus.int_ack)
            ackClr[capIdx] = EDGE_MASK[capIdx];
    end

    lc3_int_arbiter #(.NUM_SRC(NUM_SRC), .PRIO_W(PRIO_W)) uArb (
        .eligible (eligible),
        .prio     (prio),
        .winIdx   (winIdx),
        .winValid (winValid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
            irqPrev <= '0;
            en      <= '0;
            prio    <= '0;
        end else begin
            irqPrev <= irq;
            // A fresh edge outranks an ack clear landing in the same cycle.
            pending <= (EDGE_MASK & ((irq & ~irqPrev) | (pending & ~ackClr)))
                     | (~EDGE_MASK & irq);
            if (cfg_we && int'(cfg_sel) < NUM_SRC) begin
                en[cfg_sel]   <= cfg_data[PRIO_W];
                prio[cfg_sel] <= cfg_data[PRIO_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= INT_IDLE;
            capIdx         <= '0;
            bus.INT        <= 1'b0;
            bus.int_vector <= '0;
            bus.int_prio   <= '0;
        end else begin
            case (state)
                INT_IDLE: begin
                    if (winValid) begin
                        capIdx         <= winIdx;
                        bus.int_vector <= VEC_BASE + VEC_W'(winIdx);
                        bus.int_prio   <= prio[winIdx];
                        bus.INT        <= 1'b1;
                        state          <= INT_REQ;
                    end
                end
                INT_REQ: begin
                    if (bus.int_ack) begin
                        bus.INT <= 1'b0;
                        state   <= INT_HOLD;
                    end else if (!capElig) begin
                        bus.INT <= 1'b0;
                        state   <= INT_IDLE;
                    end
                end
                INT_HOLD: state <= INT_IDLE;
                default: begin
                    bus.INT <= 1'b0;
                    state   <= INT_IDLE;
                end
            endcase
        end
    end
endmodule
